// File: rtl/cic_decim_comb.sv
// CIC decimator back end: samples the last integrator once every R clocks and
// runs the sample through N pipelined M=1 comb stages with modulo-2^WIDTH arithmetic.
module cic_decim_comb #(
    parameter int WIDTH = 19,
    parameter int R     = 8,
    parameter int N     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int               CNT_W    = (R > 1) ? $clog2(R) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

    // Index 0 is the decimated capture; index k is the output of comb stage k.
    logic [CNT_W-1:0]        cnt;
    logic signed [WIDTH-1:0] comb_p [0:N];
    logic signed [WIDTH-1:0] dly_p  [1:N];
    logic [N:0]              vld_p;

    // Wrap-around is what makes the integrator/comb pair cancel, so no clipping here.
    function automatic logic signed [WIDTH-1:0] wrap_sub(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        return a - b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            vld_p <= '0;
            for (int k = 0; k <= N; k++) begin
                comb_p[k] <= '0;
            end
            for (int k = 1; k <= N; k++) begin
                dly_p[k] <= '0;
            end
        end else begin
            // Stage 0: decimating capture
            cnt      <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            vld_p[0] <= (cnt == CNT_LAST);
            if (cnt == CNT_LAST) begin
                comb_p[0] <= signed'(in);
            end
            // Stages 1..N: combs, each advancing only on its input valid
            for (int k = 1; k <= N; k++) begin
                vld_p[k] <= vld_p[k-1];
                if (vld_p[k-1]) begin
                    comb_p[k] <= wrap_sub(comb_p[k-1], dly_p[k]);
                    dly_p[k]  <= comb_p[k-1];
                end
            end
        end
    end

    assign out       = comb_p[N];
    assign out_valid = vld_p[N];

endmodule

// File: tb/tb_cic_decim_comb.sv
// Bench for cic_decim_comb: a default (R=8,N=3) and an R=1,N=1 instance share one
// input; each is compared every cycle with an N-th order difference model of its captures.
module tb_cic_decim_comb;

    localparam int W  = 19;
    localparam int R0 = 8;
    localparam int N0 = 3;
    localparam int R1 = 1;
    localparam int N1 = 1;
    localparam longint MASK = (64'sd1 <<< W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in  = '0;
    logic [W-1:0] out0, out1;
    logic         vld0, vld1;

    always #5 clk = ~clk;

    cic_decim_comb #(.WIDTH(W), .R(R0), .N(N0)) dut0 (
        .clk(clk), .rst(rst), .in(in), .out(out0), .out_valid(vld0)
    );
    cic_decim_comb #(.WIDTH(W), .R(R1), .N(N1)) dut1 (
        .clk(clk), .rst(rst), .in(in), .out(out1), .out_valid(vld1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // y[n] = sum_j (-1)^j C(n,j) x[n-j], reduced modulo 2^W; h[0] is the newest capture.
    function automatic logic [31:0] diff_n(input longint h[9], input int n);
        longint acc = 0;
        longint c   = 1;
        for (int j = 0; j <= n; j++) begin
            acc += ((j % 2) != 0 ? -c : c) * h[j];
            c = c * longint'(n - j) / longint'(j + 1);
        end
        return 32'(acc & MASK);
    endfunction

    typedef struct packed {
        int          due;
        logic [31:0] val;
    } pend_t;

    int          e0, e1;
    longint      h0[9], h1[9];
    pend_t       p0[$], p1[$];
    logic [31:0] x0_out, x1_out;
    logic        x0_vld, x1_vld;

    // Reference: edge e (counted from reset release) captures when e % R == 0 and the
    // result appears N edges later; reset drops all history and pending results.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e0 = 0; h0 = '{default: 0}; p0.delete(); x0_out = 0; x0_vld = 0;
            e1 = 0; h1 = '{default: 0}; p1.delete(); x1_out = 0; x1_vld = 0;
        end else begin
            e0++;
            if (e0 % R0 == 0) begin
                for (int j = 8; j > 0; j--) h0[j] = h0[j-1];
                h0[0] = longint'(in);
                p0.push_back('{due: e0 + N0, val: diff_n(h0, N0)});
            end
            x0_vld = 1'b0;
            if (p0.size() > 0 && p0[0].due == e0) begin
                x0_out = p0[0].val;
                x0_vld = 1'b1;
                void'(p0.pop_front());
            end
            e1++;
            if (e1 % R1 == 0) begin
                for (int j = 8; j > 0; j--) h1[j] = h1[j-1];
                h1[0] = longint'(in);
                p1.push_back('{due: e1 + N1, val: diff_n(h1, N1)});
            end
            x1_vld = 1'b0;
            if (p1.size() > 0 && p1[0].due == e1) begin
                x1_out = p1[0].val;
                x1_vld = 1'b1;
                void'(p1.pop_front());
            end
        end
    end

    bit          chk_en = 1'b0;
    bit          rec_en = 1'b0;
    logic [31:0] rec[$];
    logic [31:0] ramp_a[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_r8n3", 32'(out0), x0_out);
            check("valid_r8n3", 32'(vld0), 32'(x0_vld));
            check("out_r1n1", 32'(out1), x1_out);
            check("valid_r1n1", 32'(vld1), 32'(x1_vld));
        end
        if (rec_en && vld0) rec.push_back(32'(out0));
    end

    task automatic async_reset_check(input string tag);
        #1 rst = 1'b1;
        #1;
        check({tag, "_out0"}, 32'(out0), 32'd0);
        check({tag, "_vld0"}, 32'(vld0), 32'd0);
        check({tag, "_out1"}, 32'(out1), 32'd0);
        check({tag, "_vld1"}, 32'(vld1), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 in = W'($urandom);
        end
        rst = 1'b0;
        in  = '0;
    endtask

    task automatic run_ramp(input int edges);
        for (int t = 0; t < edges; t++) begin
            @(posedge clk);
            #1 in = W'(t + 1);
        end
    endtask

    task automatic expect_seq(input string tag, input logic [31:0] e0v, input logic [31:0] e1v,
                              input logic [31:0] e2v, input logic [31:0] e3v);
        logic [31:0] e[4];
        e = '{e0v, e1v, e2v, e3v};
        check({tag, "_count_ok"}, 32'(rec.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < rec.size(); i++) check(tag, rec[i], e[i]);
    endtask

    initial begin
        logic [W-1:0] win[4];
        bit           found;

        // Reset held with random input
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1 in = W'($urandom);
        end
        rst = 1'b0;
        in  = '0;

        // Ramp in = t from release
        rec.delete();
        rec_en = 1'b1;
        run_ramp(60);
        rec_en = 1'b0;
        ramp_a = rec;
        expect_seq("ramp", 32'h00007, 32'h7FFFA, 32'h7FFFF, 32'h00000);

        // Reset while stage 1 holds a valid sample, then replay the ramp
        found = 1'b0;
        for (int t = 60; t < 80 && !found; t++) begin
            @(posedge clk);
            #1 in = W'(t + 1);
            if (e0 % R0 == 1) found = 1'b1;
        end
        check("v1_window_found", 32'(found), 32'd1);
        async_reset_check("async_mid_ramp");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        in = '0;
        rec.delete();
        rec_en = 1'b1;
        run_ramp(60);
        rec_en = 1'b0;
        check("ramp_replay_len", 32'(rec.size()), 32'(ramp_a.size()));
        for (int i = 0; i < rec.size() && i < ramp_a.size(); i++) check("ramp_replay", rec[i], ramp_a[i]);

        // Step
        do_reset();
        in = W'(19'h00100);
        rec.delete();
        rec_en = 1'b1;
        repeat (48) @(posedge clk);
        rec_en = 1'b0;
        expect_seq("step", 32'h00100, 32'h7FE00, 32'h00100, 32'h00000);

        // Wrap-around across the 2^19 boundary
        do_reset();
        win = '{19'h7FFF0, 19'h00010, 19'h00030, 19'h00050};
        in  = win[0];
        rec.delete();
        rec_en = 1'b1;
        for (int w = 1; w < 4; w++) begin
            repeat (8) @(posedge clk);
            #1 in = win[w];
        end
        repeat (16) @(posedge clk);
        rec_en = 1'b0;
        expect_seq("wrap", 32'h7FFF0, 32'h00040, 32'h7FFD0, 32'h00000);

        // Random input with an asynchronous reset in the middle
        do_reset();
        repeat (200) begin
            @(posedge clk);
            #1 in = W'($urandom);
        end
        @(posedge clk);
        async_reset_check("async_random");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (300) begin
            @(posedge clk);
            #1 in = W'($urandom);
        end

        @(posedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
